// File: rtl/si_tag_pkg.sv
// Shared types and helpers for the tag serializer slice.
package si_tag_pkg;

    localparam int unsigned TAG_TIME_W    = 64;
    localparam int unsigned TAG_CHANNEL_W = 5;

    typedef struct packed {
        logic [TAG_TIME_W-1:0]    tagtime;
        logic [TAG_CHANNEL_W-1:0] channel;
        logic                     rising_edge;
    } tag_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic int unsigned lowest_set_index(input logic [31:0] mask);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (mask[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/si_lowest_bit_select.sv
// Lowest-set-bit picker: one-hot, binary index and "only one bit set" flag.
module si_lowest_bit_select
    import si_tag_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] one_hot,
    output logic [IDX_W-1:0] index,
    output logic             last_bit
);

    assign one_hot  = mask & (~mask + WIDTH'(1));
    assign last_bit = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);
    assign index    = IDX_W'(lowest_set_index(32'(mask)));

endmodule

// File: rtl/si_tag_serializer.sv
// Multi-lane tag beat to single-tag stream serializer, ascending lane order.
// Optional sticky tagtime ordering check: define SI_TAG_SERIALIZER_ORDER_CHECK_EN.
module si_tag_serializer
    import si_tag_pkg::*;
#(
    parameter int unsigned NUMBER_OF_WORDS = 4,
    parameter int unsigned LANE_W          = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [TAG_TIME_W*NUMBER_OF_WORDS-1:0] s_axis_tagtime,
    input  logic [TAG_CHANNEL_W*NUMBER_OF_WORDS-1:0] s_axis_channel,
    input  logic [NUMBER_OF_WORDS-1:0]            s_axis_rising_edge,
    input  logic [NUMBER_OF_WORDS-1:0]            s_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [TAG_TIME_W-1:0]                 m_axis_tagtime,
    output logic [TAG_CHANNEL_W-1:0]              m_axis_channel,
    output logic                                  m_axis_rising_edge,
    output logic [LANE_W-1:0]                     m_axis_lane,
    output logic                                  m_axis_tlast,
    output logic                                  order_error
);

    tag_t [NUMBER_OF_WORDS-1:0] hold_q;
    tag_t [NUMBER_OF_WORDS-1:0] in_tags;
    logic [NUMBER_OF_WORDS-1:0] pending_q;
    logic [NUMBER_OF_WORDS-1:0] sel_oh;
    logic [LANE_W-1:0]          sel_idx;
    logic                       sel_last;
    logic                       busy;
    logic                       in_hs;
    logic                       out_hs;
    tag_t                       sel_tag;

    si_lowest_bit_select #(
        .WIDTH (NUMBER_OF_WORDS),
        .IDX_W (LANE_W)
    ) u_sel (
        .mask     (pending_q),
        .one_hot  (sel_oh),
        .index    (sel_idx),
        .last_bit (sel_last)
    );

    always_comb begin
        in_tags = '0;
        for (int unsigned i = 0; i < NUMBER_OF_WORDS; i++) begin
            in_tags[i].tagtime     = s_axis_tagtime[i*TAG_TIME_W +: TAG_TIME_W];
            in_tags[i].channel     = s_axis_channel[i*TAG_CHANNEL_W +: TAG_CHANNEL_W];
            in_tags[i].rising_edge = s_axis_rising_edge[i];
        end
    end

    assign busy          = |pending_q;
    assign m_axis_tvalid = busy;
    assign m_axis_tlast  = sel_last;
    // Slot frees in the same cycle its final tag is taken, so beats chain without bubbles.
    assign s_axis_tready = !busy || (m_axis_tready && sel_last);
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign out_hs        = busy && m_axis_tready;

    assign sel_tag            = hold_q[sel_idx];
    assign m_axis_tagtime     = sel_tag.tagtime;
    assign m_axis_channel     = sel_tag.channel;
    assign m_axis_rising_edge = sel_tag.rising_edge;
    assign m_axis_lane        = sel_idx;

    // A load in the same cycle as the final output overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            hold_q    <= '0;
        end else if (in_hs) begin
            pending_q <= s_axis_tkeep;
            hold_q    <= in_tags;
        end else if (out_hs) begin
            pending_q <= pending_q & ~sel_oh;
        end
    end

`ifdef SI_TAG_SERIALIZER_ORDER_CHECK_EN
    logic [TAG_TIME_W-1:0] last_time_q;
    logic                  seen_q;
    logic                  order_error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_time_q   <= '0;
            seen_q        <= 1'b0;
            order_error_q <= 1'b0;
        end else if (out_hs) begin
            last_time_q <= sel_tag.tagtime;
            seen_q      <= 1'b1;
            if (seen_q && (sel_tag.tagtime < last_time_q)) begin
                order_error_q <= 1'b1;
            end
        end
    end

    assign order_error = order_error_q;
`else
    assign order_error = 1'b0;
`endif

endmodule

// File: tb/tb_si_tag_serializer.sv
// Self-checking bench for si_tag_serializer against a queue-based tag model.
module tb_si_tag_serializer;

    localparam int unsigned N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [64*N-1:0] s_axis_tagtime;
    logic [5*N-1:0]  s_axis_channel;
    logic [N-1:0]    s_axis_rising_edge;
    logic [N-1:0]    s_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [63:0]     m_axis_tagtime;
    logic [4:0]      m_axis_channel;
    logic            m_axis_rising_edge;
    logic [1:0]      m_axis_lane;
    logic            m_axis_tlast;
    logic            order_error;

    si_tag_serializer #(.NUMBER_OF_WORDS(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tagtime     (s_axis_tagtime),
        .s_axis_channel     (s_axis_channel),
        .s_axis_rising_edge (s_axis_rising_edge),
        .s_axis_tkeep       (s_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tagtime     (m_axis_tagtime),
        .m_axis_channel     (m_axis_channel),
        .m_axis_rising_edge (m_axis_rising_edge),
        .m_axis_lane        (m_axis_lane),
        .m_axis_tlast       (m_axis_tlast),
        .order_error        (order_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] t;
        logic [4:0]  ch;
        logic        r;
        int unsigned lane;
    } exp_t;

    exp_t        q[$];
    logic [63:0] bt[N];
    logic [4:0]  bc[N];
    logic        br[N];
    int          n_checks = 0;
    int          n_err    = 0;
    logic        seen_m   = 1'b0;
    logic        err_m    = 1'b0;
    logic        rz_m     = 1'b1;
    logic [63:0] last_t_m = '0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_lane(input int unsigned i, input logic [63:0] t, input logic [4:0] ch, input logic r);
        bt[i] = t;
        bc[i] = ch;
        br[i] = r;
    endtask

    task automatic set_beat_rand();
        for (int unsigned i = 0; i < N; i++)
            set_lane(i, 64'($urandom_range(0, 1000)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic tv, input logic [N-1:0] keep, input logic mr,
                         input logic r, output logic acc);
        logic exp_v;
        logic exp_str;
        logic exp_oe;
        exp_t f;
        rst           = r;
        s_axis_tvalid = tv;
        s_axis_tkeep  = keep;
        m_axis_tready = mr;
        for (int unsigned i = 0; i < N; i++) begin
            s_axis_tagtime[i*64 +: 64]  = bt[i];
            s_axis_channel[i*5 +: 5]    = bc[i];
            s_axis_rising_edge[i]       = br[i];
        end
        #1;
        exp_v   = (q.size() != 0);
        exp_str = !exp_v || (mr && q.size() == 1);
`ifdef SI_TAG_SERIALIZER_ORDER_CHECK_EN
        exp_oe  = err_m;
`else
        exp_oe  = 1'b0;
`endif
        chk("s_tready", 64'(s_axis_tready), 64'(exp_str));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
        chk("order_error", 64'(order_error), 64'(exp_oe));
        if (exp_v) begin
            f = q[0];
            chk("tagtime", m_axis_tagtime, f.t);
            chk("channel", 64'(m_axis_channel), 64'(f.ch));
            chk("rising", 64'(m_axis_rising_edge), 64'(f.r));
            chk("lane", 64'(m_axis_lane), 64'(f.lane));
            chk("tlast", 64'(m_axis_tlast), 64'(q.size() == 1));
        end else begin
            chk("idle_lane", 64'(m_axis_lane), 64'd0);
            chk("idle_tlast", 64'(m_axis_tlast), 64'd0);
            if (rz_m) begin
                chk("rst_tagtime", m_axis_tagtime, 64'd0);
                chk("rst_channel", 64'(m_axis_channel), 64'd0);
                chk("rst_rising", 64'(m_axis_rising_edge), 64'd0);
            end
        end
        acc = tv && exp_str && !r;
        @(posedge clk);
        if (r) begin
            q.delete();
            seen_m = 1'b0;
            err_m  = 1'b0;
            rz_m   = 1'b1;
        end else begin
            if (exp_v && mr) begin
                f = q.pop_front();
                if (seen_m && f.t < last_t_m) err_m = 1'b1;
                last_t_m = f.t;
                seen_m   = 1'b1;
            end
            if (acc) begin
                q.delete();
                rz_m = 1'b0;
                for (int unsigned i = 0; i < N; i++)
                    if (keep[i]) q.push_back('{bt[i], bc[i], br[i], i});
            end
        end
        #1;
    endtask

    initial begin
        logic acc;
        logic holding;
        logic tv;
        logic [N-1:0] keep;
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tkeep = '0; m_axis_tready = 1'b0;
        s_axis_tagtime = '0; s_axis_channel = '0; s_axis_rising_edge = '0;
        for (int unsigned i = 0; i < N; i++) set_lane(i, 64'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Sparse beat 1010
        set_lane(0, 64'd7, 5'd1, 1'b1);
        set_lane(1, 64'd100, 5'd2, 1'b1);
        set_lane(2, 64'd9, 5'd3, 1'b1);
        set_lane(3, 64'd300, 5'd21, 1'b0);
        cycle(1'b1, 4'b1010, 1'b1, 1'b0, acc);
        chk("beat1010_acc", 64'(acc), 64'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Back-to-back full beats
        set_beat_rand();
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 4'b1111, 1'b1, 1'b0, acc);
            if (acc) set_beat_rand();
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Single tag held under backpressure
        set_lane(0, 64'd555, 5'd9, 1'b1);
        cycle(1'b1, 4'b0001, 1'b0, 1'b0, acc);
        set_beat_rand();
        for (int k = 0; k < 5; k++) cycle(1'b1, 4'b0110, 1'b0, 1'b0, acc);
        cycle(1'b1, 4'b0110, 1'b1, 1'b0, acc);
        chk("bp_next_acc", 64'(acc), 64'd1);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Empty beat is swallowed, next beat taken straight after
        set_beat_rand();
        cycle(1'b1, 4'b0000, 1'b1, 1'b0, acc);
        chk("empty_acc", 64'(acc), 64'd1);
        set_beat_rand();
        cycle(1'b1, 4'b0100, 1'b1, 1'b0, acc);
        chk("after_empty_acc", 64'(acc), 64'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Reset with pending 1100
        set_beat_rand();
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Ordering: 500 then 400 flags, persists; equal times do not
        set_lane(0, 64'd500, 5'd0, 1'b1);
        set_lane(1, 64'd400, 5'd1, 1'b1);
        cycle(1'b1, 4'b0011, 1'b1, 1'b0, acc);
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b1, acc);
        set_lane(1, 64'd500, 5'd1, 1'b1);
        cycle(1'b1, 4'b0011, 1'b1, 1'b0, acc);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Random traffic with random backpressure
        holding = 1'b0;
        tv      = 1'b0;
        keep    = '0;
        for (int k = 0; k < 300; k++) begin
            if (!holding) begin
                set_beat_rand();
                tv   = 1'($urandom_range(0, 1));
                keep = N'($urandom_range(0, 15));
            end
            cycle(tv, keep, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0), acc);
            holding = tv && !acc;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
